// File: rtl/shift_mult_accumulator_if.sv
// Valid/ready bundle between the shift-add multiplier, this accumulator stage and its consumer.
// The slave modport is the accumulator's view; the master modport drives products and accepts results.
interface shift_mult_accumulator_if #(
  parameter int N     = 32,
  parameter int OUT_W = 2*N+1
);
  logic             in_valid;
  logic             in_ready;
  logic [2*N:0]     in_product;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_sum;
  logic             out_ovf;

  modport slave (
    input  in_valid,
    input  in_product,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sum,
    output out_ovf
  );

  modport master (
    output in_valid,
    output in_product,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sum,
    input  out_ovf
  );
endinterface

// File: rtl/shift_mult_accumulator.sv
// Sums LEN consecutive signed products into one dot-product result held on a valid/ready port.
// Optional macro SHIFT_MULT_ACC_SAT_EN saturates the result to OUT_W bits; otherwise it wraps.
module shift_mult_accumulator #(
  parameter int N     = 32,
  parameter int LEN   = 8,
  parameter int OUT_W = 2*N+1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  shift_mult_accumulator_if.slave bus
);
  localparam int P_W   = 2*N+1;
  localparam int ACC_W = P_W + $clog2(LEN);
  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN-1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   sum_q, sum_d;
  logic               ovf_q, ovf_d;

  logic [ACC_W-1:0]   prod_ext_s;
  logic [ACC_W-1:0]   acc_sum_s;
  logic [OUT_W-1:0]   sum_fit_s;
  logic               ovf_fit_s;
  logic               beat_s;
  logic               out_hs_s;

`ifdef SHIFT_MULT_ACC_SAT_EN
  // In range exactly when every bit above the output sign bit repeats the accumulator sign.
  function automatic logic [OUT_W:0] sat_fit(input logic [ACC_W-1:0] a);
    logic sign;
    logic in_range;
    sign     = a[ACC_W-1];
    in_range = (a[ACC_W-1:OUT_W-1] == {(ACC_W-OUT_W+1){sign}});
    if (in_range) begin
      sat_fit = {1'b0, a[OUT_W-1:0]};
    end else if (sign) begin
      sat_fit = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      sat_fit = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
    end
  endfunction
`endif

  // Handshake qualifiers and the running sum including the current beat.
  always_comb begin
    beat_s     = bus.in_valid && (state_q == ST_ACCUM);
    out_hs_s   = bus.out_ready && (state_q == ST_HOLD);
    prod_ext_s = ACC_W'($signed(bus.in_product));
    acc_sum_s  = (cnt_q == CNT_ZERO) ? prod_ext_s : (acc_q + prod_ext_s);
`ifdef SHIFT_MULT_ACC_SAT_EN
    {ovf_fit_s, sum_fit_s} = sat_fit(acc_sum_s);
`else
    ovf_fit_s = 1'b0;
    sum_fit_s = acc_sum_s[OUT_W-1:0];
`endif
  end

  // Next-state and datapath updates for the accumulate / hold sequence.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_ACCUM: begin
        if (beat_s) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_HOLD;
            acc_d   = {ACC_W{1'b0}};
            cnt_d   = CNT_ZERO;
            sum_d   = sum_fit_s;
            ovf_d   = ovf_fit_s;
          end else begin
            acc_d = acc_sum_s;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (out_hs_s) begin
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_ACCUM;
        acc_d   = {ACC_W{1'b0}};
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State register; rst outranks clear, and clear outranks any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      acc_q   <= {ACC_W{1'b0}};
      cnt_q   <= CNT_ZERO;
      sum_q   <= {OUT_W{1'b0}};
      ovf_q   <= 1'b0;
    end else if (clear) begin
      state_q <= ST_ACCUM;
      acc_q   <= {ACC_W{1'b0}};
      cnt_q   <= CNT_ZERO;
      sum_q   <= {OUT_W{1'b0}};
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_ACCUM);
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.out_sum   = sum_q;
  assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_shift_mult_accumulator.sv
// Bench for shift_mult_accumulator: vector table, directed corner sequences and a random run
// against a queue-based reference model (N=4, LEN=4, OUT_W=9 and a second OUT_W=8 instance).
module tb_shift_mult_accumulator;
  localparam int N   = 4;
  localparam int LEN = 4;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic clear = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   rnd_on = 1'b0;

  always #5 clk = ~clk;

  shift_mult_accumulator_if #(.N(N), .OUT_W(9)) b9 ();
  shift_mult_accumulator_if #(.N(N), .OUT_W(8)) b8 ();

  shift_mult_accumulator #(.N(N), .LEN(LEN), .OUT_W(9)) dut9 (
    .clk(clk), .rst(rst), .clear(clear), .bus(b9.slave));
  shift_mult_accumulator #(.N(N), .LEN(LEN), .OUT_W(8)) dut8 (
    .clk(clk), .rst(rst), .clear(clear), .bus(b8.slave));

  typedef struct {
    bit     sel;
    string  name;
    int     p0, p1, p2, p3;
    longint exp_sum;
    bit     exp_ovf;
  } vec_t;

  vec_t   vecs[$];
  longint beats[$];
  longint exp_sum_q[$];
  bit     exp_ovf_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference rule: wrap or clamp a mathematically exact sum into w bits.
  function automatic void model_fit(input longint s, input int w, output longint v, output bit o);
    longint hi, lo;
    hi = (longint'(1) <<< (w-1)) - 1;
    lo = -hi - 1;
`ifdef SHIFT_MULT_ACC_SAT_EN
    if (s > hi) begin v = hi; o = 1'b1; end
    else if (s < lo) begin v = lo; o = 1'b1; end
    else begin v = s; o = 1'b0; end
`else
    begin
      longint span;
      span = longint'(1) <<< w;
      v = s % span;
      if (v > hi) v = v - span;
      if (v < lo) v = v + span;
      o = 1'b0;
    end
`endif
  endfunction

  task automatic add_vec(input bit sel, input string nm, input int a, input int b, input int c,
                         input int d, input longint sat_sum, input bit sat_ovf, input longint wrap_sum);
    vec_t v;
    v.sel = sel; v.name = nm; v.p0 = a; v.p1 = b; v.p2 = c; v.p3 = d;
`ifdef SHIFT_MULT_ACC_SAT_EN
    v.exp_sum = sat_sum; v.exp_ovf = sat_ovf;
`else
    v.exp_sum = wrap_sum; v.exp_ovf = 1'b0;
    if (sat_ovf) v.exp_ovf = 1'b0;
    if (sat_sum == 64'sd0) v.exp_ovf = 1'b0;
`endif
    vecs.push_back(v);
  endtask

  task automatic drive(input bit sel, input bit v, input int p);
    if (sel) begin b8.in_valid = v; b8.in_product = 9'(p); end
    else     begin b9.in_valid = v; b9.in_product = 9'(p); end
  endtask

  task automatic set_ordy(input bit sel, input bit r);
    if (sel) b8.out_ready = r; else b9.out_ready = r;
  endtask

  function automatic longint rdy(input bit sel);
    return sel ? longint'(b8.in_ready) : longint'(b9.in_ready);
  endfunction
  function automatic longint ovld(input bit sel);
    return sel ? longint'(b8.out_valid) : longint'(b9.out_valid);
  endfunction
  function automatic longint oovf(input bit sel);
    return sel ? longint'(b8.out_ovf) : longint'(b9.out_ovf);
  endfunction
  function automatic longint osum(input bit sel);
    return sel ? longint'($signed(b8.out_sum)) : longint'($signed(b9.out_sum));
  endfunction

  // Offer one product and return #1 after the edge that accepted it.
  task automatic beat(input bit sel, input int p);
    int n;
    n = 0;
    drive(sel, 1'b1, p);
    @(negedge clk);
    while (rdy(sel) == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (rdy(sel) == 0) begin
      checks++; errors++;
      $display("FAIL beat_timeout: in_ready stayed 0, expected 1");
    end
    @(posedge clk); #1;
    drive(sel, 1'b0, 0);
  endtask

  task automatic finish_check(input bit sel, input longint es, input bit eo, input string nm);
    chk({nm, "_valid"}, ovld(sel), 1);
    chk({nm, "_sum"}, osum(sel), es);
    chk({nm, "_ovf"}, oovf(sel), longint'(eo));
    chk({nm, "_ready_in_hold"}, rdy(sel), 0);
    set_ordy(sel, 1'b1);
    @(posedge clk); #1;
    set_ordy(sel, 1'b0);
    chk({nm, "_valid_drop"}, ovld(sel), 0);
    chk({nm, "_ready_back"}, rdy(sel), 1);
  endtask

  task automatic run_result(input bit sel, input int a, input int b, input int c, input int d,
                            input int gmax, input longint es, input bit eo, input string nm);
    int p[4];
    p = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      beat(sel, p[i]);
      if (i < 3) begin
        chk({nm, "_early_valid"}, ovld(sel), 0);
        repeat ($urandom_range(0, gmax)) begin @(posedge clk); #1; end
      end
    end
    finish_check(sel, es, eo, nm);
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b1;
    drive(1'b0, 1'b0, 0); drive(1'b1, 1'b0, 0);
    set_ordy(1'b0, 1'b0); set_ordy(1'b1, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      chk({nm, "_rst_ready"}, rdy(s[0]), 1);
      chk({nm, "_rst_valid"}, ovld(s[0]), 0);
      chk({nm, "_rst_sum"}, osum(s[0]), 0);
      chk({nm, "_rst_ovf"}, oovf(s[0]), 0);
    end
  endtask

  // Reference model for the random phase: collect accepted beats, one expected result per LEN.
  always @(negedge clk) begin
    if (rnd_on) begin
      longint s, v;
      bit o;
      chk("rnd_in_ready", longint'(b9.in_ready), longint'(exp_sum_q.size() == 0));
      chk("rnd_out_valid", longint'(b9.out_valid), longint'(exp_sum_q.size() != 0));
      if (b9.out_valid && b9.out_ready && exp_sum_q.size() != 0) begin
        chk("rnd_sum", osum(1'b0), exp_sum_q.pop_front());
        chk("rnd_ovf", oovf(1'b0), longint'(exp_ovf_q.pop_front()));
      end
      if (b9.in_valid && b9.in_ready) begin
        beats.push_back(longint'($signed(b9.in_product)));
        if (beats.size() == LEN) begin
          s = 0;
          foreach (beats[i]) s += beats[i];
          model_fit(s, 9, v, o);
          exp_sum_q.push_back(v);
          exp_ovf_q.push_back(o);
          beats.delete();
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    b9.in_valid = 1'b0; b9.in_product = 9'd0; b9.out_ready = 1'b0;
    b8.in_valid = 1'b0; b8.in_product = 9'd0; b8.out_ready = 1'b0;

    add_vec(1'b0, "basic",     3,   -5,  10,   7,   15, 1'b0,   15);
    add_vec(1'b0, "neg_small", -1,  -1,  -1,  -1,   -4, 1'b0,   -4);
    add_vec(1'b0, "pos_edge",  64,  64,  64,  63,  255, 1'b0,  255);
    add_vec(1'b0, "neg_edge",  -64, -64, -64, -64, -256, 1'b0, -256);
    add_vec(1'b0, "pos_over",  64,  64,  64,  64,  255, 1'b1, -256);
    add_vec(1'b0, "pos_max",   255, 255, 255, 255, 255, 1'b1,  -4);
    add_vec(1'b0, "neg_max",   -256, -256, -256, -256, -256, 1'b1, 0);
    add_vec(1'b1, "w8_pos",    64,  64,  64,  64,  127, 1'b1,    0);
    add_vec(1'b1, "w8_neg",    -56, -56, -56, -56, -128, 1'b1,  32);

    do_reset("init");

    // Back-to-back table pass, then the same table with idle gaps between beats.
    foreach (vecs[i])
      run_result(vecs[i].sel, vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].p3, 0,
                 vecs[i].exp_sum, vecs[i].exp_ovf, vecs[i].name);
    foreach (vecs[i])
      run_result(vecs[i].sel, vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].p3, 3,
                 vecs[i].exp_sum, vecs[i].exp_ovf, {vecs[i].name, "_gaps"});

    // Backpressure: a waiting product must not be consumed while the result is held.
    beat(1'b0, 3); beat(1'b0, -5); beat(1'b0, 10); beat(1'b0, 7);
    drive(1'b0, 1'b1, 9);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_ready", rdy(1'b0), 0);
      chk("bp_valid", ovld(1'b0), 1);
      chk("bp_sum", osum(1'b0), 15);
    end
    set_ordy(1'b0, 1'b1);
    @(posedge clk); #1;
    set_ordy(1'b0, 1'b0);
    chk("bp_release_ready", rdy(1'b0), 1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 0);
    beat(1'b0, 1); beat(1'b0, 1); beat(1'b0, 1);
    finish_check(1'b0, 12, 1'b0, "bp_next");

    // clear mid-accumulation, with a simultaneous beat that must be ignored.
    beat(1'b0, 5); beat(1'b0, 6);
    drive(1'b0, 1'b1, 100);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    drive(1'b0, 1'b0, 0);
    chk("clr_mid_valid", ovld(1'b0), 0);
    chk("clr_mid_ready", rdy(1'b0), 1);
    run_result(1'b0, 1, 1, 1, 1, 0, 4, 1'b0, "clr_after");

    // clear while holding a result drops it.
    beat(1'b0, 2); beat(1'b0, 2); beat(1'b0, 2); beat(1'b0, 2);
    chk("clr_hold_pre_valid", ovld(1'b0), 1);
    set_ordy(1'b0, 1'b1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    set_ordy(1'b0, 1'b0);
    chk("clr_hold_valid", ovld(1'b0), 0);
    chk("clr_hold_ready", rdy(1'b0), 1);
    chk("clr_hold_sum", osum(1'b0), 0);
    run_result(1'b0, 1, 1, 1, 1, 1, 4, 1'b0, "clr_hold_after");

    // rst mid-accumulation and in HOLD.
    beat(1'b0, 7); beat(1'b0, 7);
    do_reset("rst_mid");
    run_result(1'b0, 2, 2, 2, 2, 0, 8, 1'b0, "rst_mid_after");
    beat(1'b0, 3); beat(1'b0, 3); beat(1'b0, 3); beat(1'b0, 3);
    chk("rst_hold_pre_valid", ovld(1'b0), 1);
    do_reset("rst_hold");
    run_result(1'b0, 2, 2, 2, 2, 2, 8, 1'b0, "rst_hold_after");

    // Random traffic on the 9-bit instance against the reference model.
    do_reset("rnd");
    rnd_on = 1'b1;
    repeat (1500) begin
      drive(1'b0, 1'($urandom % 2), int'($urandom_range(0, 511)));
      set_ordy(1'b0, ($urandom % 10) < 7);
      @(posedge clk); #1;
    end
    drive(1'b0, 1'b0, 0);
    set_ordy(1'b0, 1'b0);
    rnd_on = 1'b0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
